periph_bus_arbiter: RTL and testbench
=====================================

# periph_bus_arbiter

Two-master arbiter that shares one memory-mapped peripheral slave port (GPIO register block and similar `mem_valid`/`mem_ready` peripherals) between the CPU and a second requester, such as a DMA or pattern sequencer. It grants round-robin and registers the winning request onto the slave port. It returns the slave's ready and read data to the winning master only. It also masks the slave's trailing ready pulse and guards against a dead slave with a timeout.

## Interface

**Parameters**
- `TIMEOUT`, default 15: number of REQ-state cycles without `s_ready` before the transaction is force-completed. Legal range 2..255.
- `TIMEOUT_DATA`, default 32'hFFFF_FFFF: read data returned on a timed-out transaction.

**Ports**
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `m0_valid` in 1: master 0 (CPU) request. Held high until `m0_ready`.
- `m0_addr` in 32: master 0 address.
- `m0_wdata` in 32: master 0 write data.
- `m0_we` in 1: master 0 write enable.
- `m0_ready` out 1: one-cycle completion pulse to master 0.
- `m0_rdata` out 32: read data to master 0. Valid only while `m0_ready`, otherwise 0.
- `m1_valid`, `m1_addr`, `m1_wdata`, `m1_we`, `m1_ready`, `m1_rdata`: same as the m0 ports, for master 1.
- `s_valid` out 1: slave `mem_valid`.
- `s_addr` out 32: slave address.
- `s_wdata` out 32: slave write data.
- `s_we` out 1: slave write enable.
- `s_ready` in 1: slave `mem_ready`. Registered copy of `s_valid`.
- `s_q` in 32: slave read data. Combinational, valid while `s_valid`.
- `timeout_pulse` out 1: one-cycle pulse when a transaction times out.

## Operation

- **States:** IDLE, REQ, DRAIN. Reset state is IDLE.
- **IDLE:**
  - If either `mX_valid` is high, latch the winner's addr, wdata and we into the slave-side registers, record the grant, and go to REQ.
  - If neither is high, stay in IDLE.
- **Arbitration:**
  - A single requester always wins.
  - If both request, the winner is the master not granted last. The `last_grant` register resets to 1, so m0 wins the first tie.
  - `last_grant` updates only on entry to REQ.
- **REQ:**
  - `s_valid` = 1; `s_addr`, `s_wdata`, `s_we` come from the latched registers.
  - If `s_ready` = 1: assert the granted `mX_ready` combinationally for this cycle, drive `mX_rdata` = `s_q`, and go to DRAIN.
  - Else if the timeout counter = `TIMEOUT`-1: assert `mX_ready` with `mX_rdata` = `TIMEOUT_DATA`, pulse `timeout_pulse`, and go to DRAIN.
  - Else increment the counter.
  - `s_ready` wins over a timeout in the same cycle.
- **DRAIN:**
  - `s_valid` = 0, `s_we` = 0.
  - `s_ready` is ignored. The slave echoes ready one cycle after `s_valid` falls, and that echo must never reach a master.
  - Master requests are ignored. Next state is IDLE, unconditionally.
- **Write enable:** the slave writes on `we` without qualifying by `mem_valid`, so `s_we` must be 0 in every state except REQ.
- **Timeout counter:** 8 bits, cleared on entry to REQ.
- **Ungranted master:** `mX_ready` = 0 and `mX_rdata` = 0.
- **Master withdrawal:** if the granted master drops `valid` during REQ, the transaction still completes to the slave. The ready pulse is still issued and is harmless to the master.

## Timing

- **Reset values (asynchronous):**
  - State = IDLE, `last_grant` = 1, counter = 0.
  - `s_valid`, `s_we`, `s_addr`, `s_wdata` = 0.
  - `timeout_pulse` = 0. Both `mX_ready` = 0 and both `mX_rdata` = 0.
- **Reset mid-transaction:** abandons it immediately. No `mX_ready` is issued.
- **Normal latency:**
  - Request seen at edge 0 (IDLE).
  - Cycle 1: REQ, `s_valid` = 1.
  - Cycle 2: `s_ready` = 1 and `mX_ready` = 1.
  - Cycle 3: DRAIN.
  - Cycle 4: IDLE, new grant possible.
- **Back-to-back throughput:** one transaction per 4 cycles.
- **Timeout latency:** `mX_ready` asserts on the `TIMEOUT`-th REQ cycle.
- **Master rule:** masters must hold addr, wdata and we stable while `valid` is high. Only the grant edge samples them.

## Test plan

- **Single read:** m0 reads address 0x8 while `s_q` = 0x5. Required: `s_valid` high for exactly 2 cycles, `m0_ready` pulses once on cycle 2 with `m0_rdata` = 0x5, and `m1_ready` stays 0.
- **Single write:** m1 writes 0xA to address 0x4. Required: `s_we` high only in the 2 REQ cycles, `s_wdata` = 0xA, one `m1_ready` pulse, and no second pulse in DRAIN despite the echoed `s_ready`.
- **Contention:** both masters hold `valid` for 4 transactions. Required: grant order m0, m1, m0, m1, each completing 4 cycles apart.
- **Timeout:** slave ready tied low, m0 reads with `TIMEOUT` = 15. Required: `m0_ready` and `timeout_pulse` on REQ cycle 15, `m0_rdata` = 0xFFFF_FFFF, then IDLE 2 cycles later.
- **Reset mid-transaction:** assert `resetn` = 0 during REQ. Required: all outputs 0 immediately, no ready pulse, and the next tie after release grants m0.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin arbiter that shares one mem_valid/mem_ready
// peripheral slave between two masters. The winning request is registered onto
// the slave port. Ready and read data return only to the granted master. The
// slave's trailing ready echo is masked, and a dead slave is cut off by a timeout.
module periph_bus_arbiter #(
  parameter int unsigned TIMEOUT      = 15,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  // master 0 (CPU)
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  // master 1 (DMA / sequencer)
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  // shared slave port
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_we,
  input  logic        s_ready,
  input  logic [31:0] s_q,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counter value on the last REQ cycle before the transaction is forced to end
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [7:0]  r_count;

  logic        w_any_req;
  logic        w_winner;
  logic        w_done;
  logic        w_timeout;
  logic [31:0] w_rdata;

  // Arbitration: a lone requester wins, a tie goes to the master not granted last
  always_comb begin
    w_any_req = m0_valid | m1_valid;
    if (m0_valid && m1_valid) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = m1_valid;
    end
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, slave strobes and master completion; the DRAIN state swallows the ready echo
  always_comb begin
    w_next_state  = r_state;
    w_done        = 1'b0;
    w_timeout     = 1'b0;
    s_valid       = 1'b0;
    s_we          = 1'b0;
    timeout_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        s_valid = 1'b1;
        s_we    = r_we;
        if (s_ready) begin
          w_done       = 1'b1;
          w_next_state = DRAIN;
        end else if (r_count == TO_LAST) begin
          w_done        = 1'b1;
          w_timeout     = 1'b1;
          timeout_pulse = 1'b1;
          w_next_state  = DRAIN;
        end
      end
      DRAIN: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    w_rdata  = w_timeout ? TIMEOUT_DATA : s_q;
    m0_ready = w_done & ~r_last_grant;
    m1_ready = w_done & r_last_grant;
    m0_rdata = m0_ready ? w_rdata : 32'd0;
    m1_rdata = m1_ready ? w_rdata : 32'd0;
  end

  // Grant capture: latch the winner's request on entry to REQ and run the timeout counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= 1'b1;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_we         <= 1'b0;
      r_count      <= 8'd0;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_grant <= w_winner;
      r_addr       <= w_winner ? m1_addr  : m0_addr;
      r_wdata      <= w_winner ? m1_wdata : m0_wdata;
      r_we         <= w_winner ? m1_we    : m0_we;
      r_count      <= 8'd0;
    end else if (r_state == REQ && !w_done) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Testbench for periph_bus_arbiter: directed steps with a scoreboard of expected
// completions (master, read data, timeout flag) popped on every ready pulse.
module tb_periph_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_we, m1_we;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_we;
  logic [31:0] s_addr, s_wdata;
  logic        sReady;
  logic [31:0] slaveQ;
  logic        timeout_pulse;
  logic        deadSlave;

  typedef struct packed {
    logic        master;
    logic [31:0] data;
    logic        timedOut;
  } sbEntry_t;

  sbEntry_t sb[$];
  int       readyCycQ[$];

  int nVectors     = 0;
  int nMiscompares = 0;
  int cyc          = 0;
  int m0Left       = 0;
  int m1Left       = 0;
  int m0Pulses     = 0;
  int m1Pulses     = 0;
  int sValidCycles = 0;
  int sWeCycles    = 0;
  int startCyc     = 0;

  periph_bus_arbiter #(
    .TIMEOUT      (15),
    .TIMEOUT_DATA (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .m0_valid      (m0_valid),
    .m0_addr       (m0_addr),
    .m0_wdata      (m0_wdata),
    .m0_we         (m0_we),
    .m0_ready      (m0_ready),
    .m0_rdata      (m0_rdata),
    .m1_valid      (m1_valid),
    .m1_addr       (m1_addr),
    .m1_wdata      (m1_wdata),
    .m1_we         (m1_we),
    .m1_ready      (m1_ready),
    .m1_rdata      (m1_rdata),
    .s_valid       (s_valid),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_we          (s_we),
    .s_ready       (sReady),
    .s_q           (slaveQ),
    .timeout_pulse (timeout_pulse)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: ready is a registered copy of valid, unless the slave is dead
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sReady <= 1'b0;
    end else begin
      sReady <= s_valid & ~deadSlave;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected(input logic master, input logic [31:0] data, input logic timedOut);
    sbEntry_t e;
    e.master   = master;
    e.data     = data;
    e.timedOut = timedOut;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic master, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic we, input int count);
    if (master) begin
      m1_addr = addr; m1_wdata = wdata; m1_we = we; m1_valid = 1'b1; m1Left = count;
    end else begin
      m0_addr = addr; m0_wdata = wdata; m0_we = we; m0_valid = 1'b1; m0Left = count;
    end
  endtask

  // Advance to the next negedge, run the per-cycle checks and the scoreboard, act as the masters
  task automatic tick();
    sbEntry_t e;
    @(negedge clk);
    cyc++;
    if (s_valid) sValidCycles++;
    if (s_we) sWeCycles++;
    checkOutput("we_outside_req", 32'(s_we & ~s_valid), 32'd0);
    checkOutput("ready_exclusive", 32'(m0_ready & m1_ready), 32'd0);
    if (!m0_ready) checkOutput("m0_rdata_idle", m0_rdata, 32'd0);
    if (!m1_ready) checkOutput("m1_rdata_idle", m1_rdata, 32'd0);
    if (m0_ready || m1_ready) begin
      readyCycQ.push_back(cyc);
      checkOutput("ready_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("grant_master", 32'(m1_ready), 32'(e.master));
        checkOutput("ready_rdata", m1_ready ? m1_rdata : m0_rdata, e.data);
        checkOutput("timeout_flag", 32'(timeout_pulse), 32'(e.timedOut));
      end
    end else begin
      checkOutput("timeout_quiet", 32'(timeout_pulse), 32'd0);
    end
    if (m0_ready) begin
      m0Pulses++;
      if (m0Left > 0) m0Left--;
      if (m0Left == 0) m0_valid = 1'b0;
    end
    if (m1_ready) begin
      m1Pulses++;
      if (m1Left > 0) m1Left--;
      if (m1Left == 0) m1_valid = 1'b0;
    end
  endtask

  task automatic clearCounters();
    m0Pulses = 0; m1Pulses = 0; sValidCycles = 0; sWeCycles = 0;
    readyCycQ.delete();
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    checkOutput({tag, "_s_we"}, 32'(s_we), 32'd0);
    checkOutput({tag, "_s_addr"}, s_addr, 32'd0);
    checkOutput({tag, "_s_wdata"}, s_wdata, 32'd0);
    checkOutput({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
    checkOutput({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
    checkOutput({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    checkOutput({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout_pulse), 32'd0);
  endtask

  // Directed sequence: reset, read, write, contention, timeout, reset mid-transaction
  initial begin
    resetn = 1'b0; deadSlave = 1'b0; slaveQ = 32'd0;
    m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_we = 1'b0;
    m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_we = 1'b0;

    repeat (2) tick();
    checkAllIdle("reset");
    resetn = 1'b1;
    tick();

    $display("[TB] single read");
    clearCounters();
    slaveQ = 32'h5;
    applyStimulus(1'b0, 32'h8, 32'h0, 1'b0, 1);
    pushExpected(1'b0, 32'h5, 1'b0);
    tick();
    checkOutput("rd_c1_s_valid", 32'(s_valid), 32'd1);
    checkOutput("rd_c1_s_addr", s_addr, 32'h8);
    checkOutput("rd_c1_s_we", 32'(s_we), 32'd0);
    tick();
    checkOutput("rd_c2_m0_ready", 32'(m0_ready), 32'd1);
    tick();
    checkOutput("rd_c3_s_valid", 32'(s_valid), 32'd0);
    checkOutput("rd_c3_echo_masked", 32'(m0_ready), 32'd0);
    tick();
    checkOutput("rd_s_valid_cycles", sValidCycles, 2);
    checkOutput("rd_m0_pulses", m0Pulses, 1);
    checkOutput("rd_m1_pulses", m1Pulses, 0);

    $display("[TB] single write");
    clearCounters();
    slaveQ = 32'h77;
    applyStimulus(1'b1, 32'h4, 32'hA, 1'b1, 1);
    pushExpected(1'b1, 32'h77, 1'b0);
    tick();
    checkOutput("wr_c1_s_we", 32'(s_we), 32'd1);
    checkOutput("wr_c1_s_wdata", s_wdata, 32'hA);
    checkOutput("wr_c1_s_addr", s_addr, 32'h4);
    tick();
    checkOutput("wr_c2_m1_ready", 32'(m1_ready), 32'd1);
    m1_we = 1'b0;
    tick();
    checkOutput("wr_c3_s_we", 32'(s_we), 32'd0);
    checkOutput("wr_c3_echo_masked", 32'(m1_ready), 32'd0);
    tick();
    checkOutput("wr_s_we_cycles", sWeCycles, 2);
    checkOutput("wr_m1_pulses", m1Pulses, 1);
    checkOutput("wr_m0_pulses", m0Pulses, 0);

    $display("[TB] contention");
    clearCounters();
    slaveQ = 32'h1234;
    applyStimulus(1'b0, 32'h20, 32'h0, 1'b0, 2);
    applyStimulus(1'b1, 32'h24, 32'h0, 1'b0, 2);
    pushExpected(1'b0, 32'h1234, 1'b0);
    pushExpected(1'b1, 32'h1234, 1'b0);
    pushExpected(1'b0, 32'h1234, 1'b0);
    pushExpected(1'b1, 32'h1234, 1'b0);
    repeat (17) tick();
    checkOutput("cont_pulses", readyCycQ.size(), 4);
    if (readyCycQ.size() >= 4) begin
      checkOutput("cont_gap1", readyCycQ[1] - readyCycQ[0], 4);
      checkOutput("cont_gap2", readyCycQ[2] - readyCycQ[1], 4);
      checkOutput("cont_gap3", readyCycQ[3] - readyCycQ[2], 4);
    end
    checkOutput("cont_sb_empty", sb.size(), 0);

    $display("[TB] timeout");
    clearCounters();
    deadSlave = 1'b1;
    startCyc  = cyc;
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 1);
    pushExpected(1'b0, 32'hFFFF_FFFF, 1'b1);
    repeat (15) tick();
    checkOutput("to_pulse_count", readyCycQ.size(), 1);
    if (readyCycQ.size() >= 1) checkOutput("to_ready_cycle", readyCycQ[0], startCyc + 15);
    checkOutput("to_pulse", 32'(timeout_pulse), 32'd1);
    deadSlave = 1'b0;
    tick();
    checkOutput("to_drain_s_valid", 32'(s_valid), 32'd0);
    checkOutput("to_drain_m0_ready", 32'(m0_ready), 32'd0);
    slaveQ = 32'h99;
    applyStimulus(1'b1, 32'h30, 32'h0, 1'b0, 1);
    pushExpected(1'b1, 32'h99, 1'b0);
    tick();
    checkOutput("to_idle_s_valid", 32'(s_valid), 32'd0);
    tick();
    checkOutput("to_next_s_valid", 32'(s_valid), 32'd1);
    checkOutput("to_next_s_addr", s_addr, 32'h30);
    repeat (2) tick();
    checkOutput("to_sb_empty", sb.size(), 0);

    $display("[TB] reset mid-transaction");
    clearCounters();
    tick();
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1);
    tick();
    checkOutput("rst_req_s_valid", 32'(s_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkAllIdle("rst_mid");
    m0_valid = 1'b0; m0Left = 0;
    tick();
    resetn = 1'b1;
    slaveQ = 32'hAB;
    applyStimulus(1'b0, 32'h50, 32'h0, 1'b0, 1);
    applyStimulus(1'b1, 32'h54, 32'h0, 1'b0, 1);
    pushExpected(1'b0, 32'hAB, 1'b0);
    pushExpected(1'b1, 32'hAB, 1'b0);
    repeat (9) tick();
    checkOutput("rst_sb_empty", sb.size(), 0);
    checkOutput("rst_m0_pulses", m0Pulses, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
